grf_scoreboard: RTL

- Parametrised general register file for the MIPS datapath.
- Generalised in data width, register count and number of read ports.
- Adds write-to-read bypass and a per-register pending scoreboard. Decode uses the scoreboard to stall on RAW hazards against in-flight writebacks.
- Sits between decode (read/issue) and writeback (write/clear).

---
 rtl/grf_pkg.sv | 17 +
 rtl/grf_read_port.sv | 33 +++
 rtl/grf_scoreboard.sv | 94 +++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults, register-0 address and write-trace format for the
// general register file with scoreboard.
`default_nettype none

package grf_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int NRD_DEF   = 2;
    localparam int REG0_ADDR = 0;

    // Arguments: time, PC, register address, write data
    localparam string TRACE_FMT = "%0t@%h: $%0d <= %h\n";

endpackage : grf_pkg

`default_nettype wire

// File: rtl/grf_read_port.sv
// grf_read_port: one combinational read port of the register file, with
// same-cycle writeback bypass and scoreboard-based ready.
`default_nettype none

module grf_read_port
    import grf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0]                 ra_i,
    input  logic [(2**AW)-1:0][DW-1:0]    regs_i,
    input  logic [(2**AW)-1:0]            pend_i,
    input  logic                          we_i,
    input  logic [AW-1:0]                 wa_i,
    input  logic [DW-1:0]                 wd_i,
    output logic [DW-1:0]                 rd_o,
    output logic                          rrdy_o
);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (ra_i == AW'(REG0_ADDR));
    // Writes to register 0 never bypass, so a hit implies a non-zero address
    assign w_hit     = we_i && (wa_i != AW'(REG0_ADDR)) && (wa_i == ra_i);

    assign rd_o   = w_is_zero ? '0 : (w_hit ? wd_i : regs_i[ra_i]);
    assign rrdy_o = w_is_zero | ~pend_i[ra_i] | w_hit;

endmodule : grf_read_port

`default_nettype wire

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: parametrised register file with NRD bypassed read ports and a
// per-register pending bit set at issue and cleared at writeback.
`default_nettype none

module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int TRACE = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [NRD*AW-1:0]     RA,
    output logic [NRD*DW-1:0]     RD,
    output logic [NRD-1:0]        RRDY,
    input  logic                  RWE,
    input  logic [AW-1:0]         WA,
    input  logic [DW-1:0]         WD,
    input  logic [31:0]           PC,
    input  logic                  ISE,
    input  logic [AW-1:0]         ISA,
    output logic [(2**AW)-1:0]    PEND,
    output logic                  BUSY
);

    localparam int NREG = 2**AW;

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         pend_q, pend_d;
    logic                    w_wr_en;
    logic                    w_iss_en;

    assign w_wr_en  = RWE && (WA  != AW'(REG0_ADDR));
    assign w_iss_en = ISE && (ISA != AW'(REG0_ADDR));

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (w_wr_en) begin
            regs_d[WA] = WD;
            pend_d[WA] = 1'b0;
        end
        // Set after clear: a newly issued producer outranks the retiring one
        if (w_iss_en) begin
            pend_d[ISA] = 1'b1;
        end
        pend_d[REG0_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign PEND = pend_q;
    assign BUSY = |pend_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        grf_read_port #(
            .DW (DW),
            .AW (AW)
        ) u_rp (
            .ra_i   (RA[k*AW +: AW]),
            .regs_i (regs_q),
            .pend_i (pend_q),
            .we_i   (RWE),
            .wa_i   (WA),
            .wd_i   (WD),
            .rd_o   (RD[k*DW +: DW]),
            .rrdy_o (RRDY[k])
        );
    end

    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!Reset && w_wr_en) begin
                $write("%s", $sformatf(TRACE_FMT, $time, PC, WA, WD));
            end
        end
    end else begin : g_notrace
        logic w_unused_pc;
        assign w_unused_pc = ^PC;
    end

endmodule : grf_scoreboard

`default_nettype wire
